// File: rtl/carrier_gen_multi_if.sv
// Bundle of carrier generator control inputs and per-channel outputs.
// master: the controller side that drives the controls.
// slave: the carrier_gen_multi side that produces the carriers.
interface carrier_gen_multi_if #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
);
  logic [WIDTH-1:0]     period;
  logic [NCH*WIDTH-1:0] phase;
  logic [1:0]           count_mode;
  logic [1:0]           mask_mode;
  logic                 pwm_on;
  logic                 sync;
  logic [NCH*WIDTH-1:0] carrier;
  logic [NCH-1:0]       dir;
  logic [NCH-1:0]       mask_event;

  modport master (
    output period, phase, count_mode, mask_mode, pwm_on, sync,
    input  carrier, dir, mask_event
  );

  modport slave (
    input  period, phase, count_mode, mask_mode, pwm_on, sync,
    output carrier, dir, mask_event
  );
endinterface

// File: rtl/carrier_gen_multi.sv
// Multi-channel PWM carrier generator: up-sawtooth, down-sawtooth or
// up/down triangle counters sharing one peak value, each with its own
// start phase, direction flag and min/max boundary flag.
// Optional macro CARRIER_SHADOW_EN: period and count_mode are taken from
// shadow copies refreshed at a load and after channel 0 shows zero, so
// changes land on a carrier-cycle boundary instead of mid-cycle.
module carrier_gen_multi #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  carrier_gen_multi_if.slave bus
);

  logic [NCH*WIDTH-1:0] carrier_q, carrier_d;
  logic [NCH-1:0]       dir_q, dir_d;
  logic [NCH-1:0]       mask_q, mask_d;
  logic                 run_q, run_d;

  logic                 enable;
  logic                 load;
  logic [WIDTH-1:0]     per_act;
  logic [1:0]           mode_act;

  // Idle detection always looks at the live period, never the shadow.
  assign enable = bus.pwm_on && (bus.period != '0);
  assign load   = enable && (!run_q || bus.sync);
  assign run_d  = enable;

`ifdef CARRIER_SHADOW_EN
  logic [WIDTH-1:0] per_sh_q, per_sh_d;
  logic [1:0]       mode_sh_q, mode_sh_d;

  assign per_act  = per_sh_q;
  assign mode_act = mode_sh_q;

  // Refresh the shadow copies at a load or once channel 0 sits at zero.
  always_comb begin
    per_sh_d  = per_sh_q;
    mode_sh_d = mode_sh_q;
    if (load || (carrier_q[WIDTH-1:0] == '0)) begin
      per_sh_d  = bus.period;
      mode_sh_d = bus.count_mode;
    end
  end

  // Shadow register storage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_sh_q  <= '0;
      mode_sh_q <= 2'b00;
    end else begin
      per_sh_q  <= per_sh_d;
      mode_sh_q <= mode_sh_d;
    end
  end
`else
  assign per_act  = bus.period;
  assign mode_act = bus.count_mode;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] ph;
      logic [WIDTH-1:0] c_q;
      logic [WIDTH-1:0] c_d;
      logic             d_d;
      logic             m_d;

      assign ph  = bus.phase[gi*WIDTH +: WIDTH];
      assign c_q = carrier_q[gi*WIDTH +: WIDTH];

      // Per-channel next carrier, direction and boundary flag.
      always_comb begin
        c_d = '0;
        d_d = 1'b0;
        m_d = 1'b0;
        if (!enable) begin
          c_d = '0;
        end else if (load) begin
          // Start value clamped into [0, P]; no boundary flag on a load.
          c_d = (ph > bus.period) ? bus.period : ph;
          d_d = (bus.count_mode == 2'b01);
        end else begin
          case (mode_act)
            2'b00: begin
              c_d = (c_q >= per_act) ? '0 : c_q + WIDTH'(1);
              d_d = 1'b0;
            end
            2'b01: begin
              c_d = ((c_q == '0) || (c_q > per_act)) ? per_act : c_q - WIDTH'(1);
              d_d = 1'b1;
            end
            default: begin
              if (!dir_q[gi]) begin
                if (c_q >= per_act) begin
                  c_d = per_act - WIDTH'(1);
                  d_d = 1'b1;
                end else begin
                  c_d = c_q + WIDTH'(1);
                  d_d = 1'b0;
                end
              end else begin
                if (c_q == '0) begin
                  c_d = WIDTH'(1);
                  d_d = 1'b0;
                end else begin
                  c_d = c_q - WIDTH'(1);
                  d_d = 1'b1;
                end
              end
            end
          endcase
          m_d = (bus.mask_mode[0] && (c_d == '0)) ||
                (bus.mask_mode[1] && (c_d == per_act));
        end
      end

      assign carrier_d[gi*WIDTH +: WIDTH] = c_d;
      assign dir_d[gi]                    = d_d;
      assign mask_d[gi]                   = m_d;
    end
  endgenerate

  // Output and run-flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      carrier_q <= '0;
      dir_q     <= '0;
      mask_q    <= '0;
      run_q     <= 1'b0;
    end else begin
      carrier_q <= carrier_d;
      dir_q     <= dir_d;
      mask_q    <= mask_d;
      run_q     <= run_d;
    end
  end

  assign bus.carrier    = carrier_q;
  assign bus.dir        = dir_q;
  assign bus.mask_event = mask_q;

endmodule
